// File: rtl/ysyx_22041412_rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_rf_wb_ctrl
//
// Purpose:
//   Owns the single write port of the 32 x XLEN register file (x0 reads as 0).
//   Two writeback sources compete for the port:
//     - EXU (ALU results)
//     - LSU (load returns)
//   LSU normally has priority. A starvation counter forces an EXU grant after
//   STARVE_LIMIT consecutive lost cycles.
//   A pending-write scoreboard stalls the issue stage on RAW/WAW hazards.
//
// Ports:
//   clk, rst               clock and synchronous active-high reset
//   issue_valid            issue stage presents an instruction
//   issue_rs1/rs2/rd       register specifiers of the issuing instruction
//   issue_rd_wen           the instruction writes rd
//   issue_ready            no hazard; issue fires on issue_valid & issue_ready
//   exu_valid/rd/data      EXU writeback request
//   exu_ready              EXU request granted this cycle
//   lsu_valid/rd/data      LSU writeback request
//   lsu_ready              LSU request granted this cycle
//   rf_wen/rf_rw/rf_wdata  registered regfile write port (Wen, Rw, BusW)
// ---------------------------------------------------------------------------
module ysyx_22041412_rf_wb_ctrl #(
    parameter int XLEN         = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    input  logic            issue_rd_wen,
    output logic            issue_ready,

    input  logic            exu_valid,
    input  logic [4:0]      exu_rd,
    input  logic [XLEN-1:0] exu_data,
    output logic            exu_ready,

    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,

    output logic            rf_wen,
    output logic [4:0]      rf_rw,
    output logic [XLEN-1:0] rf_wdata
);

    // The counter is 3 bits wide, so the limit must fit in 1..7.
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [2:0]      starve_q, starve_d;
    logic [31:0]     pend_q,   pend_d;
    logic            rf_wen_q,   rf_wen_d;
    logic [4:0]      rf_rw_q,    rf_rw_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    logic force_exu;
    logic exu_grant;
    logic lsu_grant;

    assign force_exu = (starve_q == LIMIT);

    // Only one grant per cycle. Both grants are suppressed while reset is
    // asserted, so no handshake can complete in a reset cycle.
    assign exu_grant = !rst && exu_valid && (!lsu_valid || force_exu);
    assign lsu_grant = !rst && lsu_valid && !exu_grant;

    assign exu_ready = exu_grant;
    assign lsu_ready = lsu_grant;

    // The counter tracks consecutive cycles in which EXU waited and lost.
    // It clears as soon as EXU wins or stops requesting.
    always_comb begin
        starve_d = starve_q;
        if (!exu_valid || exu_grant) begin
            starve_d = 3'd0;
        end else if (starve_q != LIMIT) begin
            starve_d = starve_q + 3'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Write port
    // -----------------------------------------------------------------------
    // A granted rd of 0 still consumes the grant. It never asserts Wen, so
    // x0 stays hardwired to zero.
    // Without a grant, Rw/BusW keep their last value. This avoids toggling
    // the wide data bus on idle cycles.
    always_comb begin
        rf_wen_d   = 1'b0;
        rf_rw_d    = rf_rw_q;
        rf_wdata_d = rf_wdata_q;
        if (exu_grant) begin
            rf_wen_d   = (exu_rd != 5'd0);
            rf_rw_d    = exu_rd;
            rf_wdata_d = exu_data;
        end else if (lsu_grant) begin
            rf_wen_d   = (lsu_rd != 5'd0);
            rf_rw_d    = lsu_rd;
            rf_wdata_d = lsu_data;
        end
    end

    assign rf_wen   = rf_wen_q;
    assign rf_rw    = rf_rw_q;
    assign rf_wdata = rf_wdata_q;

    // -----------------------------------------------------------------------
    // Scoreboard
    // -----------------------------------------------------------------------
    logic        issue_fire;
    logic [31:0] wr_onehot;  // register being written to the regfile this cycle
    logic [31:0] set_vec;    // register being claimed by the issuing instruction
    logic [31:0] eff_pend;

    assign issue_fire = issue_valid && issue_ready && !rst;

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_pend
            assign wr_onehot[gi] = rf_wen_q && (rf_rw_q == 5'(gi));
            assign set_vec[gi]   = issue_fire && issue_rd_wen && (issue_rd == 5'(gi));

            // The regfile forwards BusW during its write cycle. A register
            // being written is therefore already safe to read this cycle.
            assign eff_pend[gi] = pend_q[gi] && !wr_onehot[gi];

            if (gi == 0) begin : g_x0
                assign pend_d[gi] = 1'b0;
            end else begin : g_xn
                // Set beats clear. A new producer issued in the write cycle
                // of an older producer must keep the register pending.
                assign pend_d[gi] = set_vec[gi] || (pend_q[gi] && !wr_onehot[gi]);
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    // Both sources are checked even if the instruction does not use them.
    // This avoids decoding the opcode here.
    logic rs1_hit;
    logic rs2_hit;
    logic rd_hit;

    assign rs1_hit = (issue_rs1 != 5'd0) && eff_pend[issue_rs1];
    assign rs2_hit = (issue_rs2 != 5'd0) && eff_pend[issue_rs2];
    assign rd_hit  = issue_rd_wen && (issue_rd != 5'd0) && eff_pend[issue_rd];

    assign issue_ready = !(rs1_hit || rs2_hit || rd_hit);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q   <= 3'd0;
            pend_q     <= 32'd0;
            rf_wen_q   <= 1'b0;
            rf_rw_q    <= 5'd0;
            rf_wdata_q <= '0;
        end else begin
            starve_q   <= starve_d;
            pend_q     <= pend_d;
            rf_wen_q   <= rf_wen_d;
            rf_rw_q    <= rf_rw_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22041412_rf_wb_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_22041412_rf_wb_ctrl.
//
// The stimulus side does the following each cycle:
//   - checks the combinational handshake outputs against a behavioural model;
//   - pushes the expected regfile-port state for the next cycle into a queue.
// An independent monitor pops that queue on the falling edge and compares it
// with the registered write port.
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_rf_wb_ctrl;

    localparam int XLEN         = 64;
    localparam int STARVE_LIMIT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            issue_valid, issue_rd_wen, issue_ready;
    logic [4:0]      issue_rs1, issue_rs2, issue_rd;
    logic            exu_valid, exu_ready, lsu_valid, lsu_ready;
    logic [4:0]      exu_rd, lsu_rd;
    logic [XLEN-1:0] exu_data, lsu_data;
    logic            rf_wen;
    logic [4:0]      rf_rw;
    logic [XLEN-1:0] rf_wdata;

    ysyx_22041412_rf_wb_ctrl #(
        .XLEN         (XLEN),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_rd_wen (issue_rd_wen),
        .issue_ready  (issue_ready),
        .exu_valid    (exu_valid),
        .exu_rd       (exu_rd),
        .exu_data     (exu_data),
        .exu_ready    (exu_ready),
        .lsu_valid    (lsu_valid),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_ready    (lsu_ready),
        .rf_wen       (rf_wen),
        .rf_rw        (rf_rw),
        .rf_wdata     (rf_wdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected regfile port for one cycle. "known" is 0 when only Wen is
    // defined, which is the case after a write to x0.
    typedef struct {
        int              cyc;
        bit              wen;
        bit              known;
        logic [4:0]      rw;
        logic [XLEN-1:0] wdata;
    } wb_exp_t;

    wb_exp_t sbq[$];

    // ---------------- behavioural model state ----------------
    bit [31:0]       m_pend;        // registers with an outstanding producer
    bit              m_wr_valid;    // a real write reaches the regfile this cycle
    int              m_wr_rd;
    int              m_losses;      // consecutive EXU arbitration losses
    logic [4:0]      m_last_rw;
    logic [XLEN-1:0] m_last_wdata;
    bit              m_known;

    // Results of the most recent step, used by the generators and directed checks.
    bit last_eg;
    bit last_lg;
    bit last_dut_exu_ready;
    bit last_dut_issue_ready;

    function automatic bit busy(input logic [4:0] r);
        return (r != 0) && m_pend[r] && !(m_wr_valid && m_wr_rd == int'(r));
    endfunction

    // Called with this cycle's inputs already driven (posedge + 1).
    // It returns at the next posedge + 1.
    task automatic step();
        bit              eg, lg, ir, fire;
        logic [4:0]      rd;
        logic [XLEN-1:0] d;
        wb_exp_t         e;

        #1;
        if (rst) begin
            eg = 0;
            lg = 0;
        end else begin
            eg = exu_valid && (!lsu_valid || m_losses >= STARVE_LIMIT);
            lg = lsu_valid && !eg;
        end
        ir = !(busy(issue_rs1) || busy(issue_rs2) || (issue_rd_wen && busy(issue_rd)));

        chk("exu_ready",   exu_ready,   eg);
        chk("lsu_ready",   lsu_ready,   lg);
        chk("issue_ready", issue_ready, ir);

        last_eg              = eg;
        last_lg              = lg;
        last_dut_exu_ready   = exu_ready;
        last_dut_issue_ready = issue_ready;

        fire  = issue_valid && ir && !rst;
        e.cyc = cyc + 1;

        if (rst) begin
            e.wen        = 0;
            e.known      = 1;
            e.rw         = '0;
            e.wdata      = '0;
            m_pend       = '0;
            m_wr_valid   = 0;
            m_losses     = 0;
            m_last_rw    = '0;
            m_last_wdata = '0;
            m_known      = 1;
        end else begin
            rd = eg ? exu_rd   : lsu_rd;
            d  = eg ? exu_data : lsu_data;

            if (eg || lg) begin
                e.wen   = (rd != 0);
                e.known = (rd != 0);
                e.rw    = rd;
                e.wdata = d;
                if (rd != 0) begin
                    m_last_rw    = rd;
                    m_last_wdata = d;
                    m_known      = 1;
                end else begin
                    m_known = 0;
                end
            end else begin
                e.wen   = 0;
                e.known = m_known;
                e.rw    = m_last_rw;
                e.wdata = m_last_wdata;
            end

            if (m_wr_valid) m_pend[m_wr_rd] = 0;
            if (fire && issue_rd_wen && issue_rd != 0) m_pend[issue_rd] = 1;
            m_wr_valid = (eg || lg) && rd != 0;
            m_wr_rd    = int'(rd);

            if (exu_valid && !eg) m_losses = (m_losses < STARVE_LIMIT) ? m_losses + 1 : STARVE_LIMIT;
            else                  m_losses = 0;
        end

        sbq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the registered write port with the scoreboard.
    always @(negedge clk) begin
        wb_exp_t e;
        if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            chk("rf_wen", rf_wen, e.wen);
            if (e.wen || e.known) begin
                chk("rf_rw",    rf_rw,    e.rw);
                chk("rf_wdata", rf_wdata, e.wdata);
            end
            if (rf_wen)
                $display("wb  cycle %0d  x%0d <= %h", cyc, rf_rw, rf_wdata);
        end
    end

    task automatic idle();
        exu_valid    = 0;
        lsu_valid    = 0;
        issue_valid  = 0;
        issue_rd_wen = 0;
        issue_rs1    = 0;
        issue_rs2    = 0;
        issue_rd     = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd,  input logic wen);
        issue_valid  = 1;
        issue_rs1    = rs1;
        issue_rs2    = rs2;
        issue_rd     = rd;
        issue_rd_wen = wen;
    endtask

    initial begin
        logic [9:0] pat;

        // Reset with every request asserted.
        rst          = 1;
        exu_valid    = 1;
        exu_rd       = 5'd3;
        exu_data     = 64'h1111;
        lsu_valid    = 1;
        lsu_rd       = 5'd4;
        lsu_data     = 64'h2222;
        issue(5'd1, 5'd2, 5'd3, 1'b1);
        m_pend       = '0;
        m_wr_valid   = 0;
        m_wr_rd      = 0;
        m_losses     = 0;
        m_last_rw    = '0;
        m_last_wdata = '0;
        m_known      = 1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 0;

        // Single EXU writeback.
        idle();
        exu_valid = 1;
        exu_rd    = 5'd5;
        exu_data  = 64'hDEAD;
        step();
        idle();
        step();

        // Contention: expect the pattern LLLLE LLLLE.
        exu_valid = 1;
        lsu_valid = 1;
        exu_rd    = 5'd10;
        lsu_rd    = 5'd11;
        for (int i = 0; i < 10; i++) begin
            step();
            pat[i] = last_dut_exu_ready;
            if (last_eg) exu_data = {$urandom, $urandom};
            if (last_lg) lsu_data = {$urandom, $urandom};
        end
        chk("contention_pattern", {54'd0, pat}, 64'b10_0001_0000);
        idle();
        step();

        // RAW stall on x7.
        issue(5'd0, 5'd0, 5'd7, 1'b1);
        step();
        issue(5'd7, 5'd0, 5'd0, 1'b0);
        step();
        step();
        chk("raw_stall", last_dut_issue_ready, 1'b0);
        exu_valid = 1;
        exu_rd    = 5'd7;
        exu_data  = 64'h77;
        step();
        chk("raw_stall_grant", last_dut_issue_ready, 1'b0);
        exu_valid = 0;
        step();
        chk("raw_release", last_dut_issue_ready, 1'b1);
        idle();
        step();

        // x0 never stalls; a writeback to x0 consumes a grant.
        issue(5'd0, 5'd0, 5'd0, 1'b1);
        step();
        issue(5'd0, 5'd0, 5'd0, 1'b0);
        exu_valid = 1;
        exu_rd    = 5'd0;
        exu_data  = 64'h5A5A;
        step();
        chk("x0_no_stall", last_dut_issue_ready, 1'b1);
        chk("x0_grant",    last_dut_exu_ready,   1'b1);
        idle();
        step();

        // Set/clear race on x9.
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        step();
        idle();
        lsu_valid = 1;
        lsu_rd    = 5'd9;
        lsu_data  = 64'h99;
        step();
        lsu_valid = 0;
        issue(5'd0, 5'd0, 5'd9, 1'b1);
        step();
        chk("race_issue_fires", last_dut_issue_ready, 1'b1);
        issue(5'd0, 5'd9, 5'd0, 1'b0);
        step();
        step();
        chk("race_pend_kept", last_dut_issue_ready, 1'b0);
        idle();
        lsu_valid = 1;
        lsu_rd    = 5'd9;
        step();
        lsu_valid = 0;
        step();

        // Randomized traffic with occasional mid-operation resets.
        for (int i = 0; i < 1500; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            // A request that is still waiting is held unchanged.
            if (!(exu_valid && !last_eg)) begin
                exu_valid = ($urandom_range(0, 9) < 6);
                exu_rd    = 5'($urandom_range(0, 7));
                exu_data  = {$urandom, $urandom};
            end
            if (!(lsu_valid && !last_lg)) begin
                lsu_valid = ($urandom_range(0, 9) < 5);
                lsu_rd    = 5'($urandom_range(0, 7));
                lsu_data  = {$urandom, $urandom};
            end
            issue(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            issue_valid = ($urandom_range(0, 3) != 0);
            step();
        end

        rst = 0;
        idle();
        step();
        step();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
